// File: rtl/aes_pkg.sv
// Shared AES datapath helpers: element width, legal Rijndael column counts,
// ShiftRows row offsets, state byte indexing and the skid-buffer state encoding.
package aes_pkg;

  localparam int AES_BYTE_W = 8;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  function automatic bit nb_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  // Rows 2 and 3 shift one extra column for 256-bit blocks.
  function automatic int shift_ofs(input int nb, input int r);
    if (nb == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  function automatic int byte_idx(input int r, input int c);
    return 4 * c + r;
  endfunction

endpackage

// File: rtl/shift_rows_map.sv
// Combinational ShiftRows permutation for NB columns; pure rewiring.
// The inverse path exists only when SHIFT_ROWS_PIPE_INV_EN is defined.
module shift_rows_map
  import aes_pkg::*;
#(
  parameter int NB     = 4,
  parameter int BYTE_W = AES_BYTE_W
) (
`ifdef SHIFT_ROWS_PIPE_INV_EN
  input  logic                   i_inv,
`endif
  input  logic [4*NB*BYTE_W-1:0] i_state,
  output logic [4*NB*BYTE_W-1:0] o_state
);

  localparam int NE = 4 * NB;

  // Element k lives at bits [BYTE_W*(NE-1-k) +: BYTE_W], so k = 0 is the MSB byte.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int DST = byte_idx(r, c);
      localparam int FWD = byte_idx(r, (c + shift_ofs(NB, r)) % NB);
`ifdef SHIFT_ROWS_PIPE_INV_EN
      localparam int INV = byte_idx(r, (c - shift_ofs(NB, r) + NB) % NB);
      assign o_state[BYTE_W*(NE-1-DST) +: BYTE_W] =
        i_inv ? i_state[BYTE_W*(NE-1-INV) +: BYTE_W]
              : i_state[BYTE_W*(NE-1-FWD) +: BYTE_W];
`else
      assign o_state[BYTE_W*(NE-1-DST) +: BYTE_W] = i_state[BYTE_W*(NE-1-FWD) +: BYTE_W];
`endif
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows stage with a two-entry skid buffer; 1-cycle latency, full throughput.
// Define SHIFT_ROWS_PIPE_INV_EN to enable per-transfer inverse shifting and the o_inv tag.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB     = 4,
  parameter int BYTE_W = AES_BYTE_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_inv,
  input  logic [4*NB*BYTE_W-1:0] i_state,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_inv,
  output logic [4*NB*BYTE_W-1:0] o_state
);

  localparam int W = 4 * NB * BYTE_W;

  if (!nb_legal(NB)) begin : g_nb_check
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  logic [W-1:0] map_dat;

`ifdef SHIFT_ROWS_PIPE_INV_EN
  localparam int EW = W + 1;
  logic [EW-1:0] in_ent;

  shift_rows_map #(.NB(NB), .BYTE_W(BYTE_W)) u_map (
    .i_inv   (i_inv),
    .i_state (i_state),
    .o_state (map_dat)
  );
  assign in_ent = {map_dat, i_inv};
`else
  localparam int EW = W;
  logic [EW-1:0] in_ent;
  logic          unused_inv;

  shift_rows_map #(.NB(NB), .BYTE_W(BYTE_W)) u_map (
    .i_state (i_state),
    .o_state (map_dat)
  );
  assign in_ent     = map_dat;
  assign unused_inv = i_inv;
`endif

  skid_state_e   state_q, state_d;
  logic          rdy_q, rdy_d;
  logic [EW-1:0] m_q, m_d;
  logic [EW-1:0] s_q, s_d;
  logic          in_xfer, out_xfer;

  assign in_xfer  = i_valid && rdy_q;
  assign out_xfer = o_valid && i_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    unique case (state_q)
      SKID_EMPTY: begin
        if (in_xfer) begin
          state_d = SKID_ONE;
          m_d     = in_ent;
        end
      end
      SKID_ONE: begin
        if (in_xfer && out_xfer) begin
          m_d = in_ent;
        end else if (in_xfer) begin
          state_d = SKID_FULL;
          s_d     = in_ent;
        end else if (out_xfer) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (out_xfer) begin
          state_d = SKID_ONE;
          m_d     = s_q;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    // Registered ready: depends only on the next buffer state, never on i_ready directly.
    rdy_d = (state_d != SKID_FULL);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= SKID_EMPTY;
      rdy_q   <= 1'b0;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  assign o_valid = (state_q != SKID_EMPTY);
  assign o_ready = rdy_q;
  assign o_state = m_q[EW-1 -: W];
`ifdef SHIFT_ROWS_PIPE_INV_EN
  assign o_inv   = m_q[0];
`else
  assign o_inv   = 1'b0;
`endif

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed bench for shift_rows_pipe (NB=4 and NB=8 instances), self-checking with immediate assertions.
module tb_shift_rows_pipe;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_valid, i_inv, i_ready;
  logic [127:0] i_state;
  logic         o_valid, o_ready, o_inv;
  logic [127:0] o_state;

  logic         valid8, inv8, ready8;
  logic [255:0] state8;
  logic         ovalid8, oready8, oinv8;
  logic [255:0] ostate8;

  int errors = 0;
  int checks = 0;

  shift_rows_pipe #(.NB(4), .BYTE_W(8)) u4 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_inv   (i_inv),
    .i_state (i_state),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_inv   (o_inv),
    .o_state (o_state)
  );

  shift_rows_pipe #(.NB(8), .BYTE_W(8)) u8 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (valid8),
    .o_ready (oready8),
    .i_inv   (inv8),
    .i_state (state8),
    .o_valid (ovalid8),
    .i_ready (ready8),
    .o_inv   (oinv8),
    .o_state (ostate8)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference ShiftRows for NB=4, written as an explicit per-byte loop.
  function automatic logic [127:0] ref4(input logic [127:0] d, input logic inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
        o[8*(15-(4*c+r)) +: 8] = d[8*(15-(4*src+r)) +: 8];
      end
    return o;
  endfunction

  function automatic logic [63:0] row8(input logic [255:0] d, input int r);
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < 8; c++) v[8*(7-c) +: 8] = d[8*(31-(4*c+r)) +: 8];
    return v;
  endfunction

  logic [127:0] bp_dat [8];
  logic [127:0] q_dat [$];
  logic         q_inv [$];
  logic         exp_inv;
  logic [127:0] exp_st, st_a, st_c;
  int sent, recv, occ;
  logic in_x, out_x;

  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0; i_inv = 1'b0; i_ready = 1'b0; i_state = '0;
    valid8  = 1'b0; inv8  = 1'b0; ready8  = 1'b0; state8  = '0;

    // Reset values
    #2;
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_inv",   o_inv,   0);
    chk("rst_state", o_state, 0);
    #6 i_rst_n = 1'b1;
    #1 chk("rel_ready_before_edge", o_ready, 0);
    @(posedge i_clk); #1;
    chk("rel_ready_after_edge", o_ready, 1);
    chk("rel_ready8", oready8, 1);

    // Forward NB=4 and NB=8 offsets
    i_valid = 1'b1; i_inv = 1'b0; i_ready = 1'b1;
    i_state = 128'hd42711aee0bf98f1b8b45de51e415230;
    valid8 = 1'b1; inv8 = 1'b0; ready8 = 1'b1;
    for (int k = 0; k < 32; k++) state8[8*(31-k) +: 8] = k[7:0];
    @(posedge i_clk); #1;
    chk("fwd4_valid", o_valid, 1);
    chk("fwd4_state", o_state, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    chk("fwd4_inv",   o_inv,   0);
    chk("nb8_valid",  ovalid8, 1);
    chk("nb8_row0",   row8(ostate8, 0), 64'h0004080C1014181C);
    chk("nb8_row1",   row8(ostate8, 1), 64'h05090D1115191D01);
    chk("nb8_row2",   row8(ostate8, 2), 64'h0E12161A1E02060A);
    chk("nb8_row3",   row8(ostate8, 3), 64'h13171B1F03070B0F);
    valid8 = 1'b0;

    // Inverse NB=4 (forward shift expected when the inverse path is not built)
    i_inv = 1'b1;
    i_state = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    @(posedge i_clk); #1;
    chk("inv4_valid", o_valid, 1);
`ifdef SHIFT_ROWS_PIPE_INV_EN
    chk("inv4_state", o_state, 128'hd42711aee0bf98f1b8b45de51e415230);
    chk("inv4_inv",   o_inv,   1);
`else
    chk("inv4_state", o_state, 128'hd4b411e5e0419830b8275dae1ebf52f1);
    chk("inv4_inv",   o_inv,   0);
`endif
    chk("nb8_drained", ovalid8, 0);
    i_valid = 1'b0; i_inv = 1'b0;
    @(posedge i_clk); #1;
    chk("drain_valid", o_valid, 0);
    chk("drain_ready", o_ready, 1);

    // Back-pressure stream, 8 states with alternating tags
    for (int i = 0; i < 8; i++) bp_dat[i] = {$urandom, $urandom, $urandom, $urandom};
    sent = 0; recv = 0; occ = 0;
    for (int cyc = 0; cyc < 300 && recv < 8; cyc++) begin
      i_valid = (sent < 8);
      i_state = bp_dat[sent % 8];
      i_inv   = sent[0];
      i_ready = (cyc < 3) ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      chk("bp_ready", o_ready, (occ < 2));
      chk("bp_valid", o_valid, (occ > 0));
      in_x  = i_valid && o_ready;
      out_x = o_valid && i_ready;
      if (out_x && q_dat.size() > 0) begin
        exp_st = q_dat.pop_front();
        exp_inv = q_inv.pop_front();
        chk("bp_state", o_state, exp_st);
        chk("bp_inv",   o_inv,   exp_inv);
        recv++;
      end
      if (in_x) begin
`ifdef SHIFT_ROWS_PIPE_INV_EN
        q_dat.push_back(ref4(i_state, i_inv));
        q_inv.push_back(i_inv);
`else
        q_dat.push_back(ref4(i_state, 1'b0));
        q_inv.push_back(1'b0);
`endif
        sent++;
      end
      occ = occ + int'(in_x) - int'(out_x);
      @(posedge i_clk); #1;
    end
    chk("bp_received", recv, 8);
    i_valid = 1'b0; i_ready = 1'b1;
    @(posedge i_clk); #1;

    // Reset mid-stall: fill both entries, then reset asynchronously
    i_ready = 1'b0; i_valid = 1'b1; i_inv = 1'b0;
    st_a = 128'h00112233445566778899aabbccddeeff;
    i_state = st_a;
    @(posedge i_clk); #1;
    i_state = 128'hffeeddccbbaa99887766554433221100;
    @(posedge i_clk); #1;
    chk("full_ready", o_ready, 0);
    chk("full_valid", o_valid, 1);
    chk("full_state", o_state, ref4(st_a, 1'b0));
    i_valid = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_ready", o_ready, 0);
    chk("arst_state", o_state, 0);
    #2 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("post_rst_ready", o_ready, 1);
    chk("post_rst_valid", o_valid, 0);
    st_c = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    i_valid = 1'b1; i_ready = 1'b1; i_state = st_c;
    @(posedge i_clk); #1;
    chk("fresh_valid", o_valid, 1);
    chk("fresh_state", o_state, ref4(st_c, 1'b0));
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    chk("fresh_only", o_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
